hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Consumer of the 5-bit write-register number produced by the EX-stage RegDst mux.
//  Tracks destination registers through EX/MEM/WB and issues one-cycle load-use stalls.
//  Drives the EX-stage ALU operand forwarding selects.
//  Keeps a saturating count of stall cycles for performance tracking.
// PARAMETERS
//  REG_W  5   register-number width
//  CNT_W  16  stall counter width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      reset, asynchronous, active-low
//  hold         in   1      pipeline freeze (memory wait); 1 = all stages hold
//  id_rs        in   REG_W  rs field of instruction in ID
//  id_rt        in   REG_W  rt field of instruction in ID
//  id_uses_rt   in   1      ID instruction reads rt as a source
//  ex_dest      in   REG_W  write register from EX-stage RegDst mux
//  ex_reg_write in   1      EX instruction writes the register file
//  ex_mem_read  in   1      EX instruction is a load
//  stall        out  1      hold PC and IF/ID; bubble ID/EX
//  fwd_a        out  2      EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b        out  2      EX operand B select, same encoding
//  stall_cnt    out  CNT_W  stall cycles since reset, saturating
// BEHAVIOUR
//  Internal registers: ex_rs_q, ex_rt_q, mem_dest_q, mem_wr_q, wb_dest_q, wb_wr_q, stall_cnt.
//  Reset (rst_n=0, async): all internal registers 0, so stall=0, fwd_a=fwd_b=00, stall_cnt=0.
//  stall (combinational, ID-stage view):
//    ex_mem_read & ex_reg_write & ex_dest!=0
//      & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt))
//  Rising edge, hold=0:
//    mem_dest_q<=ex_dest; mem_wr_q<=ex_reg_write & (ex_dest!=0)
//    wb_dest_q<=mem_dest_q; wb_wr_q<=mem_wr_q
//    if stall: ex_rs_q<=0, ex_rt_q<=0 (bubble); stall_cnt<=stall_cnt+1 unless all ones
//    else: ex_rs_q<=id_rs; ex_rt_q<=id_uses_rt ? id_rt : 0
//  Rising edge, hold=1: every internal register keeps its value; stall_cnt does not increment.
//    The stall output is still evaluated.
//  Caller contract: while stall=1, the datapath zeroes ex_reg_write and ex_mem_read in ID/EX next cycle.
//  fwd_a (combinational from registered state; fwd_b identical on ex_rt_q):
//    10 if mem_wr_q & mem_dest_q==ex_rs_q & ex_rs_q!=0
//    else 01 if wb_wr_q & wb_dest_q==ex_rs_q & ex_rs_q!=0
//    else 00
//  Priority: MEM beats WB when both match (newest value wins).
//  Register 0: never stalls, never forwards.
//  Latency: stall is same-cycle. Forwarding applies to the instruction that reaches EX on the next
//    non-hold edge.
//  Load followed by a dependent instruction: exactly one stall cycle, then fwd=01 (from WB).
//    No 10 select ever targets a load result.
//  Reset asserted mid-stall: stall drops immediately; shadows clear; no forwarding on release.
//  Simultaneous hold & stall: stall stays high across the whole hold; count increments once,
//    on the releasing edge.
// TESTING
//  1. Reset: rst_n=0 with ex_mem_read=1, ex_dest=id_rs=5 -> stall=0, fwd=00, cnt=0.
//  2. add $3 then sub uses $3 as rs: ex_dest=3, ex_reg_write=1 -> next cycle fwd_a=10.
//     Following cycle, with $3 reused as rt, fwd_b=01.
//  3. lw $4 then add rt=$4: stall=1 one cycle; bubble; next EX fwd_b=01; stall_cnt=1.
//  4. Double hit: $7 written in MEM and WB, EX reads $7 -> fwd_a=10.
//     Writes to $0 -> fwd=00, stall=0.
//  5. hold=1 for 3 cycles during load-use -> stall=1 throughout; shadows frozen.
//     stall_cnt increments by 1 after release.
//  6. CNT_W=2, four load-use stalls -> stall_cnt saturates at 3.
//     rst_n pulse mid-stall -> everything returns to 0 asynchronously.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and EX-stage operand forwarding for a classic 5-stage pipeline.
// Tracks destination registers through EX/MEM/WB and keeps a saturating count of stall cycles.
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // Source registers of the instruction currently in EX
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    // Destination shadows of the instructions in MEM and WB
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;
    logic             mem_wr_q, mem_wr_d;
    logic [REG_W-1:0] wb_dest_q, wb_dest_d;
    logic             wb_wr_q, wb_wr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_dest_nz;
    logic rs_hit;
    logic rt_hit;
    logic load_use;

    assign ex_dest_nz = (ex_dest != REG_ZERO);
    assign rs_hit     = (ex_dest == id_rs);
    assign rt_hit     = id_uses_rt & (ex_dest == id_rt);
    assign load_use   = ex_mem_read & ex_reg_write & ex_dest_nz & (rs_hit | rt_hit);

    // Gated by rst_n so an asserted reset drops the stall without waiting for a clock edge.
    assign stall = rst_n & load_use;

    // MEM/WB shadows hold only nonzero destinations in their write flags; the src check
    // keeps $0 from ever forwarding even if a shadow happens to hold zero.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] mem_dest,
        input logic             mem_wr,
        input logic [REG_W-1:0] wb_dest,
        input logic             wb_wr
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (src != REG_ZERO) begin
            if (mem_wr && (mem_dest == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_wr && (wb_dest == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs_q, mem_dest_q, mem_wr_q, wb_dest_q, wb_wr_q);
        fwd_b = fwd_sel(ex_rt_q, mem_dest_q, mem_wr_q, wb_dest_q, wb_wr_q);
    end

    always_comb begin
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        mem_dest_d  = mem_dest_q;
        mem_wr_d    = mem_wr_q;
        wb_dest_d   = wb_dest_q;
        wb_wr_d     = wb_wr_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            mem_dest_d = ex_dest;
            mem_wr_d   = ex_reg_write & ex_dest_nz;
            wb_dest_d  = mem_dest_q;
            wb_wr_d    = mem_wr_q;
            if (stall) begin
                // Bubble into EX: no sources, so nothing forwards to it
                ex_rs_d = REG_ZERO;
                ex_rt_d = REG_ZERO;
                if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
            end else begin
                ex_rs_d = id_rs;
                ex_rt_d = id_uses_rt ? id_rt : REG_ZERO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_dest_q  <= '0;
            mem_wr_q    <= 1'b0;
            wb_dest_q   <= '0;
            wb_wr_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_dest_q  <= mem_dest_d;
            mem_wr_q    <= mem_wr_d;
            wb_dest_q   <= wb_dest_d;
            wb_wr_q     <= wb_wr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: an instruction-level pipeline model drives the unit and a
// scoreboard queue of expected outputs is drained by an independent monitor.
module tb_hazard_forward_unit;

    localparam int REG_W = 5;
    localparam int EW    = 1 + 2 + 2 + 16 + 2;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rt;
        logic [REG_W-1:0] dest;
        logic             wr;
        logic             ld;
    } instr_t;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_dest;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [15:0]      stall_cnt;
    logic             stall_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;
    logic [1:0]       stall_cnt_s;

    hazard_forward_unit #(.REG_W(REG_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_forward_unit #(.REG_W(REG_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    // ---------------- reference model ----------------
    // Pipeline contents as whole instructions; the forwarding source is found by searching the
    // older in-flight instructions newest-first for a real (nonzero) register write.
    instr_t        id_i;
    instr_t        ex_i;
    instr_t        mem_i;
    instr_t        wb_i;
    logic          ex_bubble;
    instr_t        ex_src_i;
    instr_t        dir_q[$];
    logic          rand_mode;
    logic [15:0]   m_cnt16;
    logic [1:0]    m_cnt2;

    function automatic instr_t mk(input int rs, input int rt, input bit u,
                                  input int dest, input bit wr, input bit ld);
        instr_t t;
        t.rs      = REG_W'(rs);
        t.rt      = REG_W'(rt);
        t.uses_rt = u;
        t.dest    = REG_W'(dest);
        t.wr      = wr;
        t.ld      = ld;
        return t;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    function automatic bit writes(input instr_t t);
        return t.wr && (t.dest != 0);
    endfunction

    function automatic logic [1:0] source_of(input logic [REG_W-1:0] r);
        if (r == 0) return 2'b00;
        if (writes(mem_i) && mem_i.dest == r) return 2'b10;
        if (writes(wb_i) && wb_i.dest == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic instr_t next_instr();
        instr_t t;
        if (dir_q.size() > 0) begin
            t = dir_q.pop_front();
        end else if (rand_mode) begin
            t.rs      = REG_W'($urandom_range(0, 7));
            t.rt      = REG_W'($urandom_range(0, 7));
            t.uses_rt = 1'($urandom_range(0, 1));
            t.dest    = REG_W'($urandom_range(0, 7));
            t.ld      = ($urandom_range(0, 2) == 0);
            t.wr      = ($urandom_range(0, 5) != 0);
        end else begin
            t = nop();
        end
        return t;
    endfunction

    task automatic model_reset();
        ex_i      = nop();
        mem_i     = nop();
        wb_i      = nop();
        ex_src_i  = nop();
        ex_bubble = 1'b1;
        m_cnt16   = '0;
        m_cnt2    = '0;
    endtask

    // One clock: drive ID/EX pins at negedge, push the expected outputs, then move the model
    // across the coming rising edge.
    task automatic drive_cycle(input logic r, input logic h);
        logic       st;
        logic [1:0] fa;
        logic [1:0] fb;
        @(negedge clk);
        rst_n        = r;
        hold         = h;
        id_rs        = id_i.rs;
        id_rt        = id_i.rt;
        id_uses_rt   = id_i.uses_rt;
        ex_dest      = ex_i.dest;
        ex_reg_write = ex_i.wr;
        ex_mem_read  = ex_i.ld;
        if (!r) begin
            model_reset();
            // the EX/ID pins were sampled above; reset does not change what is driven now
        end
        st = r && ex_i.ld && writes(ex_i) &&
             (ex_i.dest == id_i.rs || (id_i.uses_rt && ex_i.dest == id_i.rt));
        fa = ex_bubble ? 2'b00 : source_of(ex_src_i.rs);
        fb = (ex_bubble || !ex_src_i.uses_rt) ? 2'b00 : source_of(ex_src_i.rt);
        exp_q.push_back({st, fa, fb, m_cnt16, m_cnt2});
        if (!r) begin
            id_i = nop();
        end else if (!h) begin
            wb_i  = mem_i;
            mem_i = ex_i;
            if (st) begin
                ex_i      = nop();
                ex_bubble = 1'b1;
                if (m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 16'd1;
                if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
            end else begin
                ex_i      = id_i;
                ex_src_i  = id_i;
                ex_bubble = 1'b0;
                id_i      = next_instr();
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", {15'd0, stall}, {15'd0, e[22]});
                check("fwd_a", {14'd0, fwd_a}, {14'd0, e[21:20]});
                check("fwd_b", {14'd0, fwd_b}, {14'd0, e[19:18]});
                check("stall_cnt", stall_cnt, e[17:2]);
                check("stall_cnt_sat", {14'd0, stall_cnt_s}, {14'd0, e[1:0]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rand_mode    = 1'b0;
        rst_n        = 1'b0;
        hold         = 1'b0;
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rt   = 1'b0;
        ex_dest      = '0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        model_reset();
        id_i = nop();

        // Reset with a would-be load-use hazard on the pins
        id_i = mk(5, 0, 1'b0, 0, 1'b0, 1'b0);
        ex_i = mk(0, 0, 1'b0, 5, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0);
        id_i = mk(5, 0, 1'b0, 0, 1'b0, 1'b0);
        ex_i = mk(0, 0, 1'b0, 5, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0);
        run(2);

        // ALU result forwarded from EX/MEM, then from MEM/WB to rt
        dir_q.push_back(mk(1, 2, 1'b1, 3, 1'b1, 1'b0));
        dir_q.push_back(mk(3, 0, 1'b0, 5, 1'b1, 1'b0));
        dir_q.push_back(mk(0, 3, 1'b1, 6, 1'b1, 1'b0));
        run(7);

        // Load then dependent rt use: one stall, then MEM/WB forward
        dir_q.push_back(mk(1, 0, 1'b0, 4, 1'b1, 1'b1));
        dir_q.push_back(mk(2, 4, 1'b1, 6, 1'b1, 1'b0));
        run(7);

        // $7 in both MEM and WB, then writes/loads to $0
        dir_q.push_back(mk(1, 2, 1'b1, 7, 1'b1, 1'b0));
        dir_q.push_back(mk(1, 2, 1'b1, 7, 1'b1, 1'b0));
        dir_q.push_back(mk(7, 7, 1'b1, 8, 1'b1, 1'b0));
        dir_q.push_back(mk(1, 2, 1'b1, 0, 1'b1, 1'b0));
        dir_q.push_back(mk(1, 2, 1'b1, 0, 1'b1, 1'b1));
        dir_q.push_back(mk(0, 0, 1'b1, 9, 1'b1, 1'b0));
        run(10);

        // Load-use held for three cycles
        dir_q.push_back(mk(1, 0, 1'b0, 9, 1'b1, 1'b1));
        dir_q.push_back(mk(9, 3, 1'b1, 10, 1'b1, 1'b0));
        run(2);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1);
        run(5);

        // Repeated load-use pairs drive the narrow counter into saturation
        for (int k = 0; k < 4; k++) begin
            dir_q.push_back(mk(1, 0, 1'b0, 11, 1'b1, 1'b1));
            dir_q.push_back(mk(11, 0, 1'b0, 12, 1'b1, 1'b0));
            run(5);
        end

        // Reset asserted while a held stall is active
        dir_q.push_back(mk(1, 0, 1'b0, 13, 1'b1, 1'b1));
        dir_q.push_back(mk(2, 13, 1'b1, 14, 1'b1, 1'b0));
        run(2);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1);
        run(4);

        // Randomized traffic with occasional holds and resets
        rand_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            drive_cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 6) == 0));
        end
        rand_mode = 1'b0;
        run(3);

        @(negedge clk);
        #5;
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
